gate_bist_controller: RTL and testbench
=======================================

# gate_bist_controller

Built-in self-test sequencer for a small combinational gate under test (GUT) such as `and_gate`. On a start pulse it walks every input combination into the GUT and holds each one for a programmable settle time. It then samples the GUT output and compares it against a golden truth table. It reports done, pass/fail, a mismatch count and the first failing vector. It replaces hand-written stimulus in gate-level benches and serves as an on-chip self-test for the gate library.

## Interface
- `N_IN`, default 2: number of GUT inputs; the sequencer applies 2^N_IN vectors. Legal range 1..6.
- `GOLDEN`, default 4'b1000 (AND): expected truth table, 2^N_IN bits wide; bit i is the expected `dut_y` for vector i.
- `SETTLE`, default 1: cycles each vector is driven before it is sampled; must be ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `dut_y`  in  1  GUT output.
- `tv`  out  N_IN  test vector driven to the GUT inputs; bit 0 goes to input `a`, bit 1 to input `b`, and so on.
- `busy`  out  1  high while a run is in progress (DRIVE or SAMPLE).
- `done`  out  1  high in DONE; held until the next accepted start or reset.
- `pass`  out  1  `done` and `fail_count` == 0.
- `fail_count`  out  N_IN+1  number of mismatching vectors in the current or last run.
- `first_fail_vec`  out  N_IN  vector index of the first mismatch; meaningful only when `fail_count` ≠ 0.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, with start=1: next state DRIVE. Also `tv`←0, `fail_count`←0, `first_fail_vec`←0, settle counter←0.
- DRIVE: the settle counter increments each cycle. After SETTLE cycles in DRIVE, the next state is SAMPLE.
- SAMPLE, one cycle: at its closing edge, compare `dut_y` against `GOLDEN[tv]`.
  - On mismatch: `fail_count`++. If `fail_count` was 0, `first_fail_vec`←`tv`.
  - If `tv` is the last vector (2^N_IN−1), the next state is DONE and `tv` holds its value.
  - Otherwise `tv`++, counter←0, and the next state is DRIVE.
- DONE: `done`=1 and `pass` is valid. On start=1, perform the same initialisation as from IDLE and go to DRIVE, which begins a fresh run.
- `start` is ignored in DRIVE and SAMPLE. A held-high start in DONE triggers back-to-back runs.
- Mismatch uses case inequality (`!==`) in simulation, so X or Z on `dut_y` counts as a failure.
- `fail_count` cannot overflow, because 2^N_IN fits in N_IN+1 bits.
- `tv` changes only on a clock edge and is stable for the whole settle window.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, `tv`=0, `busy`=0, `done`=0, `pass`=0, `fail_count`=0, `first_fail_vec`=0.
- `rst_n` asserted mid-run aborts the run immediately with the reset values above. A new start is accepted on the first edge after `rst_n` deasserts.
- Call E0 the edge at which `start` is accepted.
  - `busy`=1 and `tv`=0 are valid from E0.
  - Vector i is sampled at edge E0 + (i+1)·(SETTLE+1).
  - `done` rises, and `busy` falls, after edge E0 + 2^N_IN·(SETTLE+1).
  - `pass` and `fail_count` are final in that same cycle.
- Example, defaults (N_IN=2, SETTLE=1): 8 cycles per run; `done` is high in the 9th cycle after `start`.
- `busy` and `done` are never high at the same time. `pass` is never high while `done`=0.
- The GUT path from `tv` to `dut_y` must settle within SETTLE clock periods.

## Test plan
- Defaults with a correct `and_gate` as GUT, start pulsed once:
  - `tv` steps 0,1,2,3, two cycles each.
  - `done`=1 after 8 cycles, `pass`=1, `fail_count`=0.
- GOLDEN=4'b1000 with an OR gate as GUT:
  - `fail_count`=2, `first_fail_vec`=2'b01, `pass`=0, `done`=1.
- SETTLE=3, correct AND GUT:
  - each `tv` value is held for 4 cycles; `done` after 16 cycles.
  - a `start` pulse during the run is ignored, and `busy` stays 1 throughout.
- Reset mid-run: assert `rst_n`=0 in the cycle the OR GUT vector 2 is being driven.
  - All outputs return to their reset values immediately.
  - A restart afterwards yields `fail_count`=2, not an accumulated count.
- Restart from DONE: run the OR GUT, then swap in the AND GUT and pulse `start`.
  - Counts clear at the start edge.
  - The second run ends with `pass`=1 and `fail_count`=0.
- `dut_y` forced to X for vector 3 on the AND GUT:
  - `fail_count`=1, `first_fail_vec`=2'b11, `pass`=0.

Source files
------------

// File: rtl/gate_bist_if.sv
// Bundle between the BIST sequencer and whoever owns the gate under test:
// run request, GUT output, test vector and run status.
interface gate_bist_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            dut_y;
  logic [N_IN-1:0] tv;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   fail_count;
  logic [N_IN-1:0] first_fail_vec;

  // master: host plus GUT (drives start, returns dut_y); slave: the sequencer
  modport master (
    output start, dut_y,
    input  tv, busy, done, pass, fail_count, first_fail_vec
  );
  modport slave (
    input  start, dut_y,
    output tv, busy, done, pass, fail_count, first_fail_vec
  );
endinterface

// File: rtl/gate_bist_controller.sv
// BIST sequencer for a small combinational gate. It walks all 2^N_IN vectors,
// holds each one for SETTLE cycles, samples the gate output and checks it
// against the GOLDEN truth table.
module gate_bist_controller #(
  parameter int                    N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]  GOLDEN = 4'b1000,
  parameter int                    SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  gate_bist_if.slave  bus
);
  localparam int              NVEC     = 1 << N_IN;
  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NVEC - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] tv_q, tv_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN:0]   fcnt_q, fcnt_d;
  logic [N_IN-1:0] ffv_q, ffv_d;
  logic            mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tv_q    <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      ffv_q   <= '0;
    end else begin
      state_q <= state_d;
      tv_q    <= tv_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      ffv_q   <= ffv_d;
    end
  end

  // Case inequality so an X/Z gate output is reported as a failure in sim
  assign mismatch = (bus.dut_y !== GOLDEN[tv_q]);

  always_comb begin
    state_d = state_q;
    tv_d    = tv_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    ffv_d   = ffv_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_DRIVE;
          tv_d    = '0;
          cnt_d   = '0;
          fcnt_d  = '0;
          ffv_d   = '0;
        end
      end
      S_DRIVE: begin
        // Counter holds on the last settle cycle so it never wraps
        if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      S_SAMPLE: begin
        if (mismatch) begin
          fcnt_d = fcnt_q + (N_IN+1)'(1);
          if (fcnt_q == '0) ffv_d = tv_q;
        end
        if (tv_q == LAST_VEC) begin
          state_d = S_DONE;
        end else begin
          tv_d    = tv_q + N_IN'(1);
          cnt_d   = '0;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.tv             = tv_q;
  assign bus.busy           = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign bus.done           = (state_q == S_DONE);
  assign bus.pass           = (state_q == S_DONE) && (fcnt_q == '0);
  assign bus.fail_count     = fcnt_q;
  assign bus.first_fail_vec = ffv_q;
endmodule

// File: tb/tb_gate_bist_controller.sv
// Directed bench for gate_bist_controller: one default instance and one with
// SETTLE=3, each driving a behavioural AND/OR/X-injecting gate model.
module tb_gate_bist_controller;
  localparam int          N    = 2;
  localparam logic [3:0]  GOLD = 4'b1000;
  localparam int          G_AND = 0, G_OR = 1, G_XAND = 2;

  typedef struct {
    logic [2:0] fc;
    logic [1:0] ffv;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   sel = 0;
  int   m0 = G_AND, m1 = G_AND;
  exp_t sb[$];

  gate_bist_if #(.N_IN(N)) b0 ();
  gate_bist_if #(.N_IN(N)) b1 ();

  gate_bist_controller u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  gate_bist_controller #(.N_IN(N), .GOLDEN(GOLD), .SETTLE(3)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  always #5 clk = ~clk;

  function automatic logic gut(input logic [1:0] v, input int m);
    case (m)
      G_AND:   return v[0] & v[1];
      G_OR:    return v[0] | v[1];
      default: return (v == 2'd3) ? 1'bx : (v[0] & v[1]);
    endcase
  endfunction

  assign b0.dut_y = gut(b0.tv, m0);
  assign b1.dut_y = gut(b1.tv, m1);

  logic [1:0] mon_tv, mon_ffv;
  logic [2:0] mon_fc;
  logic       mon_busy, mon_done, mon_pass;
  always_comb begin
    mon_tv = b0.tv; mon_ffv = b0.first_fail_vec; mon_fc = b0.fail_count;
    mon_busy = b0.busy; mon_done = b0.done; mon_pass = b0.pass;
    if (sel == 1) begin
      mon_tv = b1.tv; mon_ffv = b1.first_fail_vec; mon_fc = b1.fail_count;
      mon_busy = b1.busy; mon_done = b1.done; mon_pass = b1.pass;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 1) b1.start = v;
    else          b0.start = v;
  endtask

  // Golden model: walk the truth table against the gate model
  function automatic exp_t model(input int m);
    exp_t e;
    logic y;
    e.fc = '0; e.ffv = '0;
    for (int v = 0; v < 4; v++) begin
      y = gut(2'(v), m);
      if (y !== GOLD[v]) begin
        if (e.fc == 0) e.ffv = 2'(v);
        e.fc = e.fc + 3'd1;
      end
    end
    e.pass = (e.fc == 0);
    return e;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_tv"},   32'(mon_tv),   0);
    chk({tag, "_busy"}, 32'(mon_busy), 0);
    chk({tag, "_done"}, 32'(mon_done), 0);
    chk({tag, "_pass"}, 32'(mon_pass), 0);
    chk({tag, "_fc"},   32'(mon_fc),   0);
    chk({tag, "_ffv"},  32'(mon_ffv),  0);
  endtask

  // Full run; called at a negedge, start is accepted at the next posedge (E0).
  task automatic run(input string tag, input int s, input int settle, input int mode,
                     input bit poke);
    exp_t e;
    int   total;
    sel = s;
    if (s == 1) m1 = mode; else m0 = mode;
    sb.push_back(model(mode));
    total = 4 * (settle + 1);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    for (int k = 0; k < total; k++) begin
      chk({tag, "_busy"}, 32'(mon_busy), 1);
      chk({tag, "_done"}, 32'(mon_done), 0);
      chk({tag, "_pass"}, 32'(mon_pass), 0);
      chk({tag, "_tv"},   32'(mon_tv),   32'(k / (settle + 1)));
      if (k == 0) chk({tag, "_fc_clr"}, 32'(mon_fc), 0);
      if (poke) set_start(k == 5);
      @(negedge clk);
    end
    set_start(1'b0);
    chk({tag, "_done_end"}, 32'(mon_done), 1);
    chk({tag, "_busy_end"}, 32'(mon_busy), 0);
    chk({tag, "_tv_end"},   32'(mon_tv),   3);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_fc"},   32'(mon_fc),   32'(e.fc));
      chk({tag, "_pass"}, 32'(mon_pass), 32'(e.pass));
      if (e.fc != 0) chk({tag, "_ffv"}, 32'(mon_ffv), 32'(e.ffv));
    end
    @(negedge clk);
    chk({tag, "_done_hold"}, 32'(mon_done), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    b0.start = 1'b0;
    b1.start = 1'b0;
    #1;
    sel = 0; #0 check_reset("rst0");
    sel = 1; #0 check_reset("rst1");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run("and_s1", 0, 1, G_AND, 1'b0);
    run("or_s1", 0, 1, G_OR, 1'b0);
    chk("or_ffv_abs", 32'(b0.first_fail_vec), 1);
    chk("or_fc_abs",  32'(b0.fail_count), 2);
    run("restart_and", 0, 1, G_AND, 1'b0);
    run("and_s3_poke", 1, 3, G_AND, 1'b1);
    run("xand", 0, 1, G_XAND, 1'b0);

    // Abort while vector 2 is being driven on the OR gate
    sel = 0; m0 = G_OR;
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_tv_pre", 32'(mon_tv), 2);
    chk("abort_busy_pre", 32'(mon_busy), 1);
    rst_n = 1'b0;
    #1 check_reset("abort");
    @(negedge clk);
    rst_n = 1'b1;
    run("after_abort", 0, 1, G_OR, 1'b0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
